bcd_count_ctrl: RTL and testbench
=================================

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning the number of BCD digits in the counter.
REQ-002 SHALL have port clk  in  1  system clock, all state updates on the rising edge.
REQ-003 SHALL have port resetn  in  1  reset: asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both 1 on a clock edge.
REQ-006 SHALL have port cmd_op  in  2  opcode: 00 CLEAR, 01 LOAD, 10 START, 11 STOP.
REQ-007 SHALL have port cmd_data  in  4*NDIG  BCD operand: the preset for LOAD, the target for START.
REQ-008 SHALL have port cmd_up  in  1  direction (1 = up, 0 = down), sampled only on an accepted START.
REQ-009 SHALL have port tick  in  1  single-cycle count-enable strobe.
REQ-010 SHALL have port count  out  4*NDIG  current BCD value, registered.
REQ-011 SHALL have port running  out  1  high while in state RUN.
REQ-012 SHALL have port done  out  1  single-cycle pulse when the target is reached.
REQ-013 SHALL have port err  out  1  sticky flag for a rejected command.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and HOLD.
REQ-015 SHALL deassert cmd_ready for exactly one cycle after each accepted command; cmd_ready SHALL be 1 otherwise.
REQ-016 SHALL, on accepted CLEAR from any state, set count to 0, clear err and go to IDLE.
REQ-017 SHALL, on accepted LOAD, set count to cmd_data on the same edge; the state is unchanged.
REQ-018 SHALL, on accepted START from any state, latch target = cmd_data and dir = cmd_up, and go to RUN.
REQ-019 SHALL, on accepted STOP, go from RUN to HOLD; STOP in IDLE or HOLD has no effect.
REQ-020 SHALL, in RUN with tick = 1, step count by one in direction dir, with ripple carry or borrow across digits in the same cycle.
REQ-021 SHALL ignore tick in IDLE and HOLD.
REQ-022 SHALL wrap count up from all-9s to 0, and down from 0 to all-9s; running is unaffected by wrap.
REQ-023 SHALL, when a RUN step makes count equal target, go to IDLE on that edge and assert done for that one cycle, while count already equals target.
REQ-024 SHALL count a full 10^NDIG ticks before done when START is given with target equal to the current count; done SHALL NOT fire immediately.
REQ-025 SHALL give an accepted command priority over a tick in the same cycle; that tick is dropped.
REQ-026 SHALL reject LOAD or START carrying any cmd_data digit > 9: no state or count change, err set to 1 and held until CLEAR or reset.
REQ-027 SHALL keep the count value unchanged across a STOP followed by a START (resume).

Reset
REQ-028 SHALL, while resetn = 0, asynchronously force the following: state IDLE, count 0, target 0, dir 1, done 0, err 0, running 0, cmd_ready 0.
REQ-029 SHALL set cmd_ready to 1 on the first clock edge after resetn deasserts.
REQ-030 SHALL abort a RUN when reset is asserted mid-count, with no done pulse.

Structure
REQ-031 SHALL place the opcode constants, the state encoding, the BCD digit width (4) and the maximum digit value (9) in a shared package, bcd_ctrl_pkg.
REQ-032 SHALL instantiate NDIG copies of sub-module bcd_digit, each with ports en, up, load, d, q and combinational carry/borrow out.

Verification
REQ-033 SHALL cover: reset, then LOAD 0095, then START target 0100 up, then 5 ticks -> count 0096..0100, done pulse on the 0100 cycle, state IDLE.
REQ-034 SHALL cover: LOAD 0000, then START target 9997 down, then 3 ticks -> count 9999, 9998, 9997, one done pulse.
REQ-035 SHALL cover: START with target equal to count 0042, up -> done after exactly 10000 ticks, not before.
REQ-036 SHALL cover: STOP after 2 ticks, then 3 ticks in HOLD, then START -> count unchanged during HOLD; counting resumes.
REQ-037 SHALL cover: LOAD 00A3 -> err = 1 and count unchanged; then CLEAR -> err = 0 and count 0000.
REQ-038 SHALL cover: cmd_valid together with tick in the same cycle -> tick dropped; resetn low mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared constants for the BCD count controller: opcodes, FSM encoding and
// BCD digit limits, plus a digit validity helper.
package bcd_ctrl_pkg;

    localparam int           DIGIT_W   = 4;
    localparam logic [3:0]   DIGIT_MAX = 4'd9;

    localparam logic [1:0]   OP_CLEAR  = 2'b00;
    localparam logic [1:0]   OP_LOAD   = 2'b01;
    localparam logic [1:0]   OP_START  = 2'b10;
    localparam logic [1:0]   OP_STOP   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: parallel load, up/down step with wrap, and a combinational
// carry/borrow out that enables the next more-significant digit.
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] q_next,
    output logic               co
);

    logic [DIGIT_W-1:0] r_q;
    logic [DIGIT_W-1:0] w_next;

    always_comb begin
        w_next = r_q;
        if (load) begin
            w_next = d;
        end else if (en) begin
            if (up) begin
                w_next = (r_q == DIGIT_MAX) ? '0 : DIGIT_W'(r_q + 4'd1);
            end else begin
                w_next = (r_q == '0) ? DIGIT_MAX : DIGIT_W'(r_q - 4'd1);
            end
        end
    end

    // Carry/borrow only when this digit is actually stepping across its limit.
    assign co     = en && (up ? (r_q == DIGIT_MAX) : (r_q == '0));
    assign q      = r_q;
    assign q_next = w_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Command-driven multi-digit BCD up/down counter with a target compare,
// IDLE/RUN/HOLD control FSM, one-cycle done pulse and sticky error flag.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [NDIG*DIGIT_W-1:0] cmd_data,
    input  logic                    cmd_up,
    input  logic                    tick,
    output logic [NDIG*DIGIT_W-1:0] count,
    output logic                    running,
    output logic                    done,
    output logic                    err
);

    localparam int W = NDIG * DIGIT_W;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_target;
    logic           r_dir;
    logic           r_done;
    logic           r_err;
    logic           r_ready;

    logic           w_accept;
    logic [NDIG-1:0] w_dig_ok;
    logic           w_data_ok;
    logic           w_clear;
    logic           w_load;
    logic           w_start;
    logic           w_stop;
    logic           w_reject;
    logic           w_step;
    logic           w_hit;
    logic           w_digit_load;
    logic [NDIG:0]  w_carry;
    logic           w_unused_wrap;
    logic [W-1:0]   w_count;
    logic [W-1:0]   w_count_next;

    assign w_accept  = cmd_valid && r_ready;
    assign w_data_ok = &w_dig_ok;

    assign w_clear  = w_accept && (cmd_op == OP_CLEAR);
    assign w_load   = w_accept && (cmd_op == OP_LOAD)  && w_data_ok;
    assign w_start  = w_accept && (cmd_op == OP_START) && w_data_ok;
    assign w_stop   = w_accept && (cmd_op == OP_STOP);
    assign w_reject = w_accept && ((cmd_op == OP_LOAD) || (cmd_op == OP_START)) && !w_data_ok;

    // Any handshake, even a rejected or no-op one, swallows a same-cycle tick.
    assign w_step       = (r_state == ST_RUN) && tick && !w_accept;
    assign w_digit_load = w_clear || w_load;
    assign w_carry[0]   = w_step;
    assign w_unused_wrap = w_carry[NDIG];

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            assign w_dig_ok[gi] = digit_ok(cmd_data[gi*DIGIT_W +: DIGIT_W]);

            bcd_digit u_digit (
                .clk    (clk),
                .resetn (resetn),
                .en     (w_carry[gi]),
                .up     (r_dir),
                .load   (w_digit_load),
                .d      (w_clear ? '0 : cmd_data[gi*DIGIT_W +: DIGIT_W]),
                .q      (w_count[gi*DIGIT_W +: DIGIT_W]),
                .q_next (w_count_next[gi*DIGIT_W +: DIGIT_W]),
                .co     (w_carry[gi+1])
            );
        end
    endgenerate

    // Compare against the post-step value so done coincides with count == target.
    assign w_hit = w_step && (w_count_next == r_target);

    always_comb begin
        w_state_next = r_state;
        if (w_clear) begin
            w_state_next = ST_IDLE;
        end else if (w_start) begin
            w_state_next = ST_RUN;
        end else if (w_stop && (r_state == ST_RUN)) begin
            w_state_next = ST_HOLD;
        end else if (w_hit) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_dir    <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_hit;
            r_ready <= !w_accept;
            if (w_start) begin
                r_target <= cmd_data;
                r_dir    <= cmd_up;
            end
            if (w_clear) begin
                r_err <= 1'b0;
            end else if (w_reject) begin
                r_err <= 1'b1;
            end
        end
    end

    assign count     = w_count;
    assign running   = (r_state == ST_RUN);
    assign done      = r_done;
    assign err       = r_err;
    assign cmd_ready = r_ready;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl: load/start/stop/clear sequences with
// hand-computed BCD values, wrap, full-cycle target, error and reset abort.
module tb_bcd_count_ctrl;

    localparam int NDIG = 4;
    localparam int W    = NDIG * 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_up = 1'b1;
    logic         tick = 1'b0;
    logic [W-1:0] count;
    logic         running;
    logic         done;
    logic         err;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] CLEAR = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] START = 2'b10;
    localparam logic [1:0] STOP  = 2'b11;

    bcd_count_ctrl #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_up    (cmd_up),
        .tick      (tick),
        .count     (count),
        .running   (running),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; the command is accepted on the rising edge between.
    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic up);
        int n = 0;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_up    = up;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("cmd op=%0d data=%04h up=%0d -> count=%04h running=%0b err=%0b",
                 op, data, up, count, running, err);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        $display("tick -> count=%04h running=%0b done=%0b", count, running, done);
    endtask

    initial begin
        int first_done;

        // Reset state
        #3;
        chk("rst_count",   32'(count),     32'h0);
        chk("rst_running", 32'(running),   32'd0);
        chk("rst_done",    32'(done),      32'd0);
        chk("rst_err",     32'(err),       32'd0);
        chk("rst_ready",   32'(cmd_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        // Up count 0095 -> 0100 with done on the last step
        send_cmd(LOAD, 16'h0095, 1'b1);
        chk("load_count",   32'(count),   32'h0095);
        chk("load_running", 32'(running), 32'd0);
        chk("ready_low_after_cmd", 32'(cmd_ready), 32'd0);
        send_cmd(START, 16'h0100, 1'b1);
        chk("start_running", 32'(running), 32'd1);
        chk("start_count",   32'(count),   32'h0095);
        do_tick(); chk("up_0096", 32'(count), 32'h0096); chk("up_done0", 32'(done), 32'd0);
        do_tick(); chk("up_0097", 32'(count), 32'h0097);
        do_tick(); chk("up_0098", 32'(count), 32'h0098);
        do_tick(); chk("up_0099", 32'(count), 32'h0099); chk("up_done3", 32'(done), 32'd0);
        do_tick(); chk("up_0100", 32'(count), 32'h0100);
        chk("up_done",    32'(done),    32'd1);
        chk("up_idle",    32'(running), 32'd0);
        do_tick();
        chk("up_done_pulse", 32'(done),  32'd0);
        chk("idle_ignores_tick", 32'(count), 32'h0100);

        // Down count with wrap 0000 -> 9999
        send_cmd(LOAD, 16'h0000, 1'b1);
        send_cmd(START, 16'h9997, 1'b0);
        do_tick(); chk("dn_9999", 32'(count), 32'h9999); chk("dn_done0", 32'(done), 32'd0);
        chk("dn_wrap_running", 32'(running), 32'd1);
        do_tick(); chk("dn_9998", 32'(count), 32'h9998); chk("dn_done1", 32'(done), 32'd0);
        do_tick(); chk("dn_9997", 32'(count), 32'h9997); chk("dn_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("dn_done_pulse", 32'(done), 32'd0);

        // Target equal to start value: full 10^NDIG ticks
        send_cmd(LOAD, 16'h0042, 1'b1);
        send_cmd(START, 16'h0042, 1'b1);
        first_done = 0;
        tick = 1'b1;
        for (int i = 1; i <= 10005; i++) begin
            @(negedge clk);
            if (done) begin
                first_done = i;
                break;
            end
        end
        tick = 1'b0;
        $display("full cycle: done after %0d ticks count=%04h", first_done, count);
        chk("full_cycle_ticks", 32'(first_done), 32'd10000);
        chk("full_cycle_count", 32'(count),      32'h0042);
        chk("full_cycle_idle",  32'(running),    32'd0);

        // STOP / HOLD / resume
        send_cmd(LOAD, 16'h0010, 1'b1);
        send_cmd(START, 16'h0020, 1'b1);
        do_tick();
        do_tick();
        chk("pre_stop_count", 32'(count), 32'h0012);
        send_cmd(STOP, 16'h0000, 1'b1);
        chk("hold_running", 32'(running), 32'd0);
        do_tick(); do_tick(); do_tick();
        chk("hold_count", 32'(count), 32'h0012);
        send_cmd(START, 16'h0020, 1'b1);
        chk("resume_running", 32'(running), 32'd1);
        chk("resume_count",   32'(count),   32'h0012);
        do_tick();
        chk("resume_step", 32'(count), 32'h0013);

        // Invalid digit rejected, then CLEAR
        send_cmd(LOAD, 16'h00A3, 1'b1);
        chk("bad_load_err",     32'(err),     32'd1);
        chk("bad_load_count",   32'(count),   32'h0013);
        chk("bad_load_running", 32'(running), 32'd1);
        send_cmd(CLEAR, 16'h0000, 1'b1);
        chk("clear_err",     32'(err),     32'd0);
        chk("clear_count",   32'(count),   32'h0000);
        chk("clear_running", 32'(running), 32'd0);
        send_cmd(STOP, 16'h0000, 1'b1);
        chk("stop_in_idle", 32'(running), 32'd0);

        // Command beats tick in the same cycle
        send_cmd(START, 16'h0005, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = LOAD; cmd_data = 16'h0003; tick = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; tick = 1'b0;
        $display("load+tick -> count=%04h running=%0b", count, running);
        chk("tick_dropped", 32'(count), 32'h0003);
        chk("tick_dropped_running", 32'(running), 32'd1);
        do_tick();
        chk("after_drop_step", 32'(count), 32'h0004);
        send_cmd(START, 16'h1F00, 1'b1);
        chk("bad_start_err",     32'(err),     32'd1);
        chk("bad_start_running", 32'(running), 32'd1);

        // Asynchronous reset mid-RUN
        #2;
        resetn = 1'b0;
        tick = 1'b1;
        #1;
        chk("arst_count",   32'(count),     32'h0);
        chk("arst_running", 32'(running),   32'd0);
        chk("arst_done",    32'(done),      32'd0);
        chk("arst_err",     32'(err),       32'd0);
        chk("arst_ready",   32'(cmd_ready), 32'd0);
        @(negedge clk);
        tick = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        $display("after reset release count=%04h ready=%0b done=%0b", count, cmd_ready, done);
        chk("arst_release_ready", 32'(cmd_ready), 32'd1);
        chk("arst_release_count", 32'(count),     32'h0);
        chk("arst_no_done",       32'(done),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
